// File: rtl/fifo_sample_pacer_if.sv
// Read-side connection between the sample FIFO and its constant-rate consumer.
interface fifo_sample_pacer_if #(
  parameter int DWIDTH = 16
);
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_read_data;
  logic              fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_sample_pacer.sv
// Constant-rate FIFO consumer: one read per DIV clocks, offset-binary conversion,
// PWM output, underrun repeat/count and re-prime after a sustained drain.
//
// state | meaning
// PRIME | waiting for the FIFO to hold data; empty ticks are not underruns
// RUN   | streaming; empty ticks repeat the last sample and count as underruns
module fifo_sample_pacer #(
  parameter int DWIDTH         = 16,
  parameter int DIV            = 1000,
  parameter int PWM_BITS       = 8,
  parameter int UNDERRUN_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  fifo_sample_pacer_if.master        fifo,
  output logic [DWIDTH-1:0]          sample,
  output logic                       sample_valid,
  output logic                       pwm_out,
  output logic                       underrun,
  output logic [15:0]                underrun_count
);

  localparam int TW = $clog2(DIV);
  localparam int EW = $clog2(UNDERRUN_LIMIT + 1);
  localparam logic [DWIDTH-1:0] MIDSCALE  = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [TW-1:0]     TICK_LAST = TW'(DIV - 1);
  localparam logic [EW-1:0]     ER_LAST   = EW'(UNDERRUN_LIMIT - 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_cnt_q;
  logic                tick;
  logic [EW-1:0]       empty_run_q;
  logic                rd_en, und_tick, limit_hit;
  logic                rd_pend_q, rep_pend_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, duty_q;
  logic [15:0]         und_cnt_q;

  assign tick              = enable && (tick_cnt_q == TICK_LAST);
  assign fifo.fifo_read_en = rd_en;
  assign underrun_count    = und_cnt_q;

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    und_tick  = 1'b0;
    limit_hit = 1'b0;
    if (tick) begin
      case (state_q)
        PRIME: begin
          if (!fifo.fifo_empty) begin
            rd_en   = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!fifo.fifo_empty) begin
            rd_en = 1'b1;
          end else begin
            und_tick = 1'b1;
            if (empty_run_q == ER_LAST) begin
              limit_hit = 1'b1;
              state_d   = PRIME;
            end
          end
        end
        default: state_d = PRIME;
      endcase
    end
    if (!enable) state_d = PRIME;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= PRIME;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      empty_run_q  <= '0;
      rd_pend_q    <= 1'b0;
      rep_pend_q   <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      pwm_out      <= 1'b0;
      sample       <= MIDSCALE;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      und_cnt_q    <= '0;
    end else if (!enable) begin
      // Disabling drops any capture in flight; debug counters survive.
      tick_cnt_q   <= '0;
      empty_run_q  <= '0;
      rd_pend_q    <= 1'b0;
      rep_pend_q   <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      pwm_out      <= 1'b0;
      sample       <= MIDSCALE;
      sample_valid <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);

      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == '1) duty_q <= sample[DWIDTH-1 -: PWM_BITS];
      pwm_out <= (pwm_cnt_q < duty_q);

      sample_valid <= rd_pend_q | rep_pend_q;
      if (rd_pend_q)
        sample <= {~fifo.fifo_read_data[DWIDTH-1], fifo.fifo_read_data[DWIDTH-2:0]};
      rd_pend_q  <= rd_en;
      rep_pend_q <= und_tick & ~limit_hit;

      if (und_tick) begin
        underrun <= 1'b1;
        if (und_cnt_q != 16'hFFFF) und_cnt_q <= und_cnt_q + 16'd1;
        empty_run_q <= limit_hit ? '0 : empty_run_q + EW'(1);
      end else if (rd_en) begin
        empty_run_q <= '0;
      end

      // DIV >= 4 guarantees no capture is pending on a limit tick.
      if (limit_hit) sample <= MIDSCALE;
    end
  end

endmodule

// File: tb/tb_fifo_sample_pacer.sv
// Self-checking bench for fifo_sample_pacer with a FIFO model and sample scoreboard.
module tb_fifo_sample_pacer;
  localparam int DW  = 16;
  localparam int DIV = 8;
  localparam int PB  = 8;
  localparam int UL  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          pwm_out;
  logic          underrun;
  logic [15:0]   underrun_count;

  fifo_sample_pacer_if #(.DWIDTH(DW)) bus ();

  fifo_sample_pacer #(
    .DWIDTH(DW), .DIV(DIV), .PWM_BITS(PB), .UNDERRUN_LIMIT(UL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo           (bus.master),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .pwm_out        (pwm_out),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    int            due;
  } exp_t;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] valid_log[$];
  int            rd_log[$];
  int            cyc = 0;
  int            m_cnt = 0;
  int            m_er = 0;
  bit            m_run = 0;
  bit            m_tick, exp_rd, rd_seen = 0;
  logic [DW-1:0] m_last = '0;
  exp_t          e;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
    return {~d[DW-1], d[DW-2:0]};
  endfunction

  // FIFO model: registered read data, popped after a read strobe seen in the previous cycle.
  always @(posedge clk) begin
    #1;
    if (rd_seen && fifo_q.size() > 0) bus.fifo_read_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // Scoreboard and timing model, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    rd_seen = bus.fifo_read_en;
    if (sample_valid) begin
      valid_log.push_back(sample);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_valid got sample=%h at cycle %0d want no pulse", sample, cyc);
      end else begin
        e = exp_q.pop_front();
        if (sample !== e.val || cyc != e.due)
          $display("FAIL sb_sample got %h at cycle %0d want %h at cycle %0d", sample, cyc, e.val, e.due);
        else n_pass++;
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      n_checks++;
      $display("FAIL sb_missing_valid got no pulse want %h at cycle %0d", exp_q[0].val, exp_q[0].due);
      exp_q.delete(0);
    end

    if (rst) begin
      m_cnt = 0; m_run = 0; m_er = 0;
      exp_q.delete();
    end else begin
      m_tick = enable && (m_cnt == DIV - 1);
      exp_rd = m_tick && !bus.fifo_empty;
      n_checks++;
      if (bus.fifo_read_en !== exp_rd)
        $display("FAIL read_en got %b want %b at cycle %0d", bus.fifo_read_en, exp_rd, cyc);
      else n_pass++;
      if (bus.fifo_read_en === 1'b1) rd_log.push_back(cyc);
      if (!enable) begin
        m_cnt = 0; m_run = 0; m_er = 0;
        exp_q.delete();
      end else begin
        if (exp_rd) begin
          m_last = (fifo_q.size() > 0) ? conv(fifo_q[0]) : 'x;
          e.val = m_last; e.due = cyc + 2;
          exp_q.push_back(e);
          m_run = 1; m_er = 0;
        end else if (m_tick && m_run) begin
          m_er++;
          if (m_er == UL) begin
            m_run = 0; m_er = 0;
          end else begin
            e.val = m_last; e.due = cyc + 2;
            exp_q.push_back(e);
          end
        end
        m_cnt = m_tick ? 0 : m_cnt + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic fifo_push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic fifo_clear();
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
  endtask

  task automatic do_reset();
    step(1);
    rst = 1'b1; enable = 1'b0;
    fifo_clear();
    step(2);
    rst = 1'b0;
    valid_log.delete(); rd_log.delete();
  endtask

  task automatic wait_valid(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (valid_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_rd(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.fifo_read_en === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    step(3);
    n_checks++; if (sample !== 16'h8000) $display("FAIL reset_sample got %h want 8000", sample); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else n_pass++;
    n_checks++; if (underrun_count !== 16'h0) $display("FAIL reset_count got %h want 0", underrun_count); else n_pass++;
    n_checks++; if (bus.fifo_read_en !== 1'b0) $display("FAIL reset_read_en got %b want 0", bus.fifo_read_en); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_prime_empty();
    do_reset();
    enable = 1'b1;
    step(10 * DIV);
    n_checks++; if (rd_log.size() != 0) $display("FAIL prime_reads got %0d want 0", rd_log.size()); else n_pass++;
    n_checks++; if (valid_log.size() != 0) $display("FAIL prime_valids got %0d want 0", valid_log.size()); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL prime_underrun got %b want 0", underrun); else n_pass++;
    n_checks++; if (sample !== 16'h8000) $display("FAIL prime_sample got %h want 8000", sample); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_stream();
    bit ok;
    logic [DW-1:0] want [3];
    want[0] = 16'h8001; want[1] = 16'h0000; want[2] = 16'hFFFF;
    do_reset();
    fifo_push(16'h0001); fifo_push(16'h8000); fifo_push(16'h7FFF);
    enable = 1'b1;
    wait_valid(3, 8 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL stream_timeout got %0d valids want 3", valid_log.size()); else n_pass++;
    if (valid_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (valid_log[i] !== want[i]) $display("FAIL stream_value[%0d] got %h want %h", i, valid_log[i], want[i]);
        else n_pass++;
      end
    end
    if (rd_log.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (rd_log[i] - rd_log[i-1] != DIV) $display("FAIL stream_read_spacing got %0d want %0d", rd_log[i] - rd_log[i-1], DIV);
        else n_pass++;
      end
    end
    step(1);
    enable = 1'b0;
    step(1);
    n_checks++; if (sample !== 16'h8000) $display("FAIL stream_idle_sample got %h want 8000", sample); else n_pass++;
  endtask

  task automatic test_underrun_limit();
    bit ok;
    do_reset();
    fifo_push(16'h1234);
    enable = 1'b1;
    wait_valid(4, 8 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL ur_timeout got %0d valids want 4", valid_log.size()); else n_pass++;
    for (int i = 0; i < valid_log.size(); i++) begin
      n_checks++;
      if (valid_log[i] !== 16'h9234) $display("FAIL ur_repeat[%0d] got %h want 9234", i, valid_log[i]);
      else n_pass++;
    end
    ok = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample === 16'h8000) begin ok = 1; break; end
    end
    n_checks++; if (!ok) $display("FAIL ur_midscale got %h want 8000", sample); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL ur_flag got %b want 1", underrun); else n_pass++;
    n_checks++; if (underrun_count !== 16'd4) $display("FAIL ur_count got %0d want 4", underrun_count); else n_pass++;
    step(3 * DIV);
    n_checks++; if (valid_log.size() != 4) $display("FAIL ur_prime_quiet got %0d valids want 4", valid_log.size()); else n_pass++;
    n_checks++; if (underrun_count !== 16'd4) $display("FAIL ur_prime_count got %0d want 4", underrun_count); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_pwm();
    int hi;
    do_reset();
    for (int i = 0; i < 150; i++) fifo_push(16'h7F00);
    enable = 1'b1;
    step(600);
    hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (pwm_out === 1'b1) hi++; end
    n_checks++; if (hi != 255) $display("FAIL pwm_ff00 got %0d high clks want 255", hi); else n_pass++;
    step(1);
    enable = 1'b0;
    fifo_clear();
    step(1);
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL pwm_disable got %b want 0", pwm_out); else n_pass++;
    for (int i = 0; i < 150; i++) fifo_push(16'h8000);
    enable = 1'b1;
    step(600);
    hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (pwm_out === 1'b1) hi++; end
    n_checks++; if (hi != 0) $display("FAIL pwm_zero got %0d high clks want 0", hi); else n_pass++;
    step(1);
    enable = 1'b0;
    fifo_clear();
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    fifo_push(16'hAAAA);
    enable = 1'b1;
    wait_valid(3, 6 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL abort_prep_timeout got %0d valids want 3", valid_log.size()); else n_pass++;
    step(1);
    fifo_push(16'h5555);
    wait_rd(2 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL abort_read_timeout got no read want read"); else n_pass++;
    step(1);
    enable = 1'b0;
    step(1);
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (sample !== 16'h8000) $display("FAIL abort_sample got %h want 8000", sample); else n_pass++;
    n_checks++; if (underrun_count !== 16'd2) $display("FAIL abort_count got %0d want 2", underrun_count); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL abort_flag got %b want 1", underrun); else n_pass++;
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL abort_pwm got %b want 0", pwm_out); else n_pass++;

    fifo_clear();
    fifo_push(16'h6666);
    enable = 1'b1;
    wait_rd(2 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL rst_read_timeout got no read want read"); else n_pass++;
    step(1);
    rst = 1'b1;
    step(1);
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (sample !== 16'h8000) $display("FAIL rst_sample got %h want 8000", sample); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rst_flag got %b want 0", underrun); else n_pass++;
    n_checks++; if (underrun_count !== 16'd0) $display("FAIL rst_count got %0d want 0", underrun_count); else n_pass++;
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL rst_pwm got %b want 0", pwm_out); else n_pass++;
    rst = 1'b0;
    enable = 1'b0;
    fifo_clear();
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    fifo_push(16'h1111);
    enable = 1'b1;
    wait_valid(1, 3 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL sat_prep_timeout got no valid want 1"); else n_pass++;
    step(1);
    force dut.und_cnt_q = 16'hFFFE;
    #1;
    release dut.und_cnt_q;
    wait_valid(2, 2 * DIV, ok);
    n_checks++; if (underrun_count !== 16'hFFFF) $display("FAIL sat_first got %h want ffff", underrun_count); else n_pass++;
    wait_valid(4, 3 * DIV, ok);
    n_checks++; if (!ok) $display("FAIL sat_timeout got %0d valids want 4", valid_log.size()); else n_pass++;
    n_checks++; if (underrun_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", underrun_count); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL sat_flag got %b want 1", underrun); else n_pass++;
    step(1);
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_read_data = '0;
    test_reset();
    test_prime_empty();
    test_stream();
    test_underrun_limit();
    test_pwm();
    test_abort();
    test_saturation();
    step(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
